// File: rtl/instruction_memory_pkg.sv
// -----------------------------------------------------------------------------
// instruction_memory_pkg
//   Shared constants for the instruction store of the single-cycle MIPS core:
//   data/address widths, the NOP encoding and the built-in boot image that is
//   present at power-up and restored by reset.
// -----------------------------------------------------------------------------
package instruction_memory_pkg;

    localparam int DATA_W      = 32;   // instruction width in bits
    localparam int ADDR_W      = 8;    // word-index width
    localparam int DEPTH       = 256;  // number of words, equals 2**ADDR_W
    localparam int PORT_ADDR_W = 32;   // width of the address ports

    localparam logic [DATA_W-1:0] NOP = '0;

    typedef logic [DATA_W-1:0] image_t [0:DEPTH-1];

    // Boot program: compute 5+3, store it, load it back, then spin on word 5.
    localparam image_t BOOT_IMAGE = '{
        0:       32'h2008_0005,  // addi $t0,$0,5
        1:       32'h2009_0003,  // addi $t1,$0,3
        2:       32'h0109_5020,  // add  $t2,$t0,$t1
        3:       32'hAC0A_0000,  // sw   $t2,0($0)
        4:       32'h8C0B_0000,  // lw   $t3,0($0)
        5:       32'h0800_0005,  // j    5
        default: NOP
    };

endpackage

// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//   Word-addressed instruction store. Reads are combinational so fetch
//   completes in the same cycle; a synchronous write port reloads the program
//   and a synchronous reset restores the boot image.
//
// Ports
//   clk          in   1   clock, all state changes on rising edge
//   reset        in   1   synchronous active-high reset (reloads boot image)
//   ImemRdAddr   in   32  read word index
//   Instruction  out  32  word at ImemRdAddr, NOP when out of range
//   ImemAddrErr  out  1   read address beyond the memory
//   ImemWrEn     in   1   program-load write enable
//   ImemWrAddr   in   32  write word index (out-of-range writes are dropped)
//   ImemWrData   in   32  word to write
// -----------------------------------------------------------------------------
module instruction_memory
    import instruction_memory_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [PORT_ADDR_W-1:0] ImemRdAddr,
    output logic [DATA_W-1:0]      Instruction,
    output logic                   ImemAddrErr,
    input  logic                   ImemWrEn,
    input  logic [PORT_ADDR_W-1:0] ImemWrAddr,
    input  logic [DATA_W-1:0]      ImemWrData
);

    // Storage starts out holding the boot image so the core can fetch
    // valid code even if reset is never asserted.
    logic [DATA_W-1:0] mem_q [0:DEPTH-1] = BOOT_IMAGE;

    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              wr_in_range;

    assign rd_idx      = ImemRdAddr[ADDR_W-1:0];
    assign wr_idx      = ImemWrAddr[ADDR_W-1:0];
    assign wr_in_range = ~|ImemWrAddr[PORT_ADDR_W-1:ADDR_W];

    // Any set upper bit means out of range; never alias onto a low word.
    assign ImemAddrErr = |ImemRdAddr[PORT_ADDR_W-1:ADDR_W];
    assign Instruction = ImemAddrErr ? NOP : mem_q[rd_idx];

    // Reset takes priority: a write presented in the reset cycle is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= BOOT_IMAGE[i];
            end
        end else if (ImemWrEn && wr_in_range) begin
            mem_q[wr_idx] <= ImemWrData;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//   Self-checking bench for instruction_memory. Expected read results are
//   queued when an address is driven and compared when the output is sampled.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

    logic        clk;
    logic        reset;
    logic [31:0] ImemRdAddr;
    logic [31:0] Instruction;
    logic        ImemAddrErr;
    logic        ImemWrEn;
    logic [31:0] ImemWrAddr;
    logic [31:0] ImemWrData;

    instruction_memory dut (
        .clk         (clk),
        .reset       (reset),
        .ImemRdAddr  (ImemRdAddr),
        .Instruction (Instruction),
        .ImemAddrErr (ImemAddrErr),
        .ImemWrEn    (ImemWrEn),
        .ImemWrAddr  (ImemWrAddr),
        .ImemWrData  (ImemWrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model [0:255];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_boot_model();
        for (int i = 0; i < 256; i++) model[i] = 32'h0;
        model[0] = 32'h2008_0005;
        model[1] = 32'h2009_0003;
        model[2] = 32'h0109_5020;
        model[3] = 32'hAC0A_0000;
        model[4] = 32'h8C0B_0000;
        model[5] = 32'h0800_0005;
    endtask

    // Drive a read address and queue what it must return.
    task automatic drive_rd(input string tag, input logic [31:0] addr,
                            input logic [31:0] instr, input logic err);
        exp_t e;
        ImemRdAddr = addr;
        e.tag   = tag;
        e.instr = instr;
        e.err   = err;
        sb_q.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the live outputs.
    task automatic sample_rd();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_instr"}, Instruction, e.instr);
            check({e.tag, "_err"}, {31'b0, ImemAddrErr}, {31'b0, e.err});
        end
    endtask

    // One read step per clock period, sampled on the falling edge.
    task automatic read_step(input string tag, input logic [31:0] addr,
                             input logic [31:0] instr, input logic err);
        @(posedge clk);
        #2;
        drive_rd(tag, addr, instr, err);
        @(negedge clk);
        sample_rd();
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 256; a++) begin
            read_step($sformatf("%s_%0d", tag, a), a, model[a], 1'b0);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ImemWrEn   = 1'b1;
        ImemWrAddr = addr;
        ImemWrData = data;
        @(posedge clk);
        #1;
        ImemWrEn = 1'b0;
        if (addr[31:8] == 24'h0) model[addr[7:0]] = data;
    endtask

    initial begin
        reset      = 1'b0;
        ImemWrEn   = 1'b0;
        ImemWrAddr = 32'h0;
        ImemWrData = 32'h0;
        ImemRdAddr = 32'h0;
        load_boot_model();

        // Power-up contents, before any reset.
        #1;
        drive_rd("preboot_w2", 32'd2, 32'h0109_5020, 1'b0);
        #1;
        sample_rd();

        // Reset for two edges.
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        sweep("boot");
        read_step("oor_256", 32'd256, 32'h0, 1'b1);
        read_step("oor_max", 32'hFFFF_FFFF, 32'h0, 1'b1);
        read_step("oor_hi", 32'h8000_0005, 32'h0, 1'b1);

        // Read-during-write on word 10: old value before the edge, new after.
        @(negedge clk);
        drive_rd("rdw_before", 32'd10, 32'h0, 1'b0);
        ImemWrEn   = 1'b1;
        ImemWrAddr = 32'd10;
        ImemWrData = 32'hDEAD_BEEF;
        #1;
        sample_rd();
        @(posedge clk);
        #1;
        ImemWrEn  = 1'b0;
        model[10] = 32'hDEAD_BEEF;
        drive_rd("rdw_after", 32'd10, 32'hDEAD_BEEF, 1'b0);
        #1;
        sample_rd();
        read_step("w9_unchanged", 32'd9, 32'h0, 1'b0);

        // Out-of-range write must not alias onto word 44.
        do_write(32'd300, 32'h5555_AAAA);
        read_step("oor_wr_w44", 32'd44, 32'h0, 1'b0);
        sweep("after_oor_wr");

        // Ordinary write to w0, then reset with a simultaneous write to w1.
        do_write(32'd0, 32'h1234_5678);
        read_step("w0_written", 32'd0, 32'h1234_5678, 1'b0);
        @(negedge clk);
        reset      = 1'b1;
        ImemWrEn   = 1'b1;
        ImemWrAddr = 32'd1;
        ImemWrData = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        ImemWrEn = 1'b0;
        load_boot_model();
        read_step("rst_w0", 32'd0, 32'h2008_0005, 1'b0);
        read_step("rst_w1", 32'd1, 32'h2009_0003, 1'b0);
        read_step("rst_w10", 32'd10, 32'h0, 1'b0);
        read_step("rst_w5", 32'd5, 32'h0800_0005, 1'b0);

        if (sb_q.size() != 0) check("sb_leftover", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
